// File: rtl/contact_collector_pkg.sv
// Shared definitions for the contact collector.
// A contact record is nine single-precision words. They are packed with cx in
// the most significant word and g2 in the least significant word.
package contact_collector_pkg;

  localparam int FLOAT_W    = 32;
  localparam int REC_FIELDS = 9;
  localparam int REC_W      = FLOAT_W * REC_FIELDS;

  // Field order, MSB first: cx, cy, cz, nx, ny, nz, depth, g1, g2.
  typedef struct packed {
    logic [FLOAT_W-1:0] cx;
    logic [FLOAT_W-1:0] cy;
    logic [FLOAT_W-1:0] cz;
    logic [FLOAT_W-1:0] nx;
    logic [FLOAT_W-1:0] ny;
    logic [FLOAT_W-1:0] nz;
    logic [FLOAT_W-1:0] depth;
    logic [FLOAT_W-1:0] g1;
    logic [FLOAT_W-1:0] g2;
  } contact_rec_t;

endpackage

// File: rtl/contact_fifo.sv
// Record storage for the contact collector: a REC_W x DEPTH array with
// wrapping read and write pointers. The read side is first-word fall-through:
// rd_data always shows the entry at the read pointer.
// The caller owns occupancy tracking. wr_en and rd_en must already be
// qualified against full and empty.
//   clk, rst      clock, async active-low reset (pointers only)
//   clr           synchronous pointer clear; overrides wr_en/rd_en
//   wr_en/wr_data write one record at the tail
//   rd_en         advance the head
//   rd_data       head record
module contact_fifo
  import contact_collector_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  contact_rec_t wr_data,
  input  logic         rd_en,
  output contact_rec_t rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  contact_rec_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so plain binary increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset. Stale entries are never exposed because the top
  // gates out_valid with the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/contact_collector.sv
// Contact collector: buffers sphere-collision contacts for a downstream consumer.
// Upstream result capture happens on a rising edge of done. A contact with
// ret=1 is queued. A contact that arrives while the buffer is full is dropped
// and latches overflow. The head record is presented first-word fall-through
// with a valid/ready handshake.
//   clk, rst                  clock, async active-low reset
//   done, ret                 upstream result strobe (level) and contact flag
//   cx..g2                    nine 32-bit record words
//   flush                     synchronous clear of contents and counters
//   out_valid/out_ready       head handshake; out_cx..out_g2 are the head fields
//   count, full               occupancy
//   overflow                  sticky drop flag
//   total                     accepted contacts, saturating at 0xFFFF
module contact_collector
  import contact_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic               ret,
  input  logic [FLOAT_W-1:0] cx,
  input  logic [FLOAT_W-1:0] cy,
  input  logic [FLOAT_W-1:0] cz,
  input  logic [FLOAT_W-1:0] normalx,
  input  logic [FLOAT_W-1:0] normaly,
  input  logic [FLOAT_W-1:0] normalz,
  input  logic [FLOAT_W-1:0] depth,
  input  logic [FLOAT_W-1:0] g1,
  input  logic [FLOAT_W-1:0] g2,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLOAT_W-1:0] out_cx,
  output logic [FLOAT_W-1:0] out_cy,
  output logic [FLOAT_W-1:0] out_cz,
  output logic [FLOAT_W-1:0] out_nx,
  output logic [FLOAT_W-1:0] out_ny,
  output logic [FLOAT_W-1:0] out_nz,
  output logic [FLOAT_W-1:0] out_depth,
  output logic [FLOAT_W-1:0] out_g1,
  output logic [FLOAT_W-1:0] out_g2,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               overflow,
  output logic [15:0]        total
);

  logic         done_q;   // done delayed one cycle, for edge detect
  logic         armed;    // done has been seen low since reset
  logic         capture;
  logic         push;
  logic         drop;
  logic         pop;
  contact_rec_t wr_rec;
  contact_rec_t head;

  // A done level that is already high when reset releases must go low before
  // it can count. Without armed, done_q=0 out of reset would fake an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      done_q <= done;
      armed  <= armed | ~done;
    end
  end

  assign capture   = done & ~done_q & armed;
  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  // full is evaluated before any same-cycle pop, so a full buffer drops the
  // incoming contact even while it is being drained.
  assign push = capture & ret & ~full & ~flush;
  assign drop = capture & ret & full;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      total    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      count    <= '0;
      total    <= '0;
      overflow <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && total != 16'hFFFF) total <= total + 16'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign wr_rec = '{cx: cx, cy: cy, cz: cz, nx: normalx, ny: normaly,
                    nz: normalz, depth: depth, g1: g1, g2: g2};

  contact_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (push),
    .wr_data (wr_rec),
    .rd_en   (pop),
    .rd_data (head)
  );

  assign out_cx    = head.cx;
  assign out_cy    = head.cy;
  assign out_cz    = head.cz;
  assign out_nx    = head.nx;
  assign out_ny    = head.ny;
  assign out_nz    = head.nz;
  assign out_depth = head.depth;
  assign out_g1    = head.g1;
  assign out_g2    = head.g2;

endmodule

// File: tb/tb_contact_collector.sv
// Bench for contact_collector: directed scenarios plus randomized traffic.
// Results are compared against a queue-based model of the collector.
module tb_contact_collector;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic done = 1'b0, ret = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] cx = '0, cy = '0, cz = '0, nx = '0, ny = '0, nz = '0;
  logic [31:0] dp = '0, g1 = '0, g2 = '0;

  logic              out_valid, full, overflow;
  logic [31:0]       out_cx, out_cy, out_cz, out_nx, out_ny, out_nz;
  logic [31:0]       out_depth, out_g1, out_g2;
  logic [CNT_W-1:0]  count;
  logic [15:0]       total;

  always #5 clk = ~clk;

  contact_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .done(done), .ret(ret),
    .cx(cx), .cy(cy), .cz(cz),
    .normalx(nx), .normaly(ny), .normalz(nz),
    .depth(dp), .g1(g1), .g2(g2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cx(out_cx), .out_cy(out_cy), .out_cz(out_cz),
    .out_nx(out_nx), .out_ny(out_ny), .out_nz(out_nz),
    .out_depth(out_depth), .out_g1(out_g1), .out_g2(out_g2),
    .count(count), .full(full), .overflow(overflow), .total(total)
  );

  int checks = 0;
  int errors = 0;

  // Model: FIFO contents as a queue, plus the scalar status values.
  logic [287:0] mq[$];
  logic         m_prev, m_armed, m_ovf;
  int           m_total;

  wire [287:0] out_rec = {out_cx, out_cy, out_cz, out_nx, out_ny, out_nz,
                          out_depth, out_g1, out_g2};

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    chk("valid", out_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("total", total, m_total);
    if (mq.size() != 0) chk("head", out_rec, mq[0]);
  endtask

  // Apply the collector rules to the inputs present at this rising edge.
  task automatic model_edge();
    bit ev, was_full;
    ev = done && !m_prev && m_armed;
    was_full = (mq.size() == DEPTH);
    if (flush) begin
      mq.delete();
      m_total = 0;
      m_ovf = 1'b0;
    end else begin
      if (out_ready && mq.size() != 0) void'(mq.pop_front());
      if (ev && ret) begin
        if (was_full) m_ovf = 1'b1;
        else begin
          mq.push_back({cx, cy, cz, nx, ny, nz, dp, g1, g2});
          if (m_total < 65535) m_total++;
        end
      end
    end
    if (!done) m_armed = 1'b1;
    m_prev = done;
  endtask

  // Check the settled outputs at the falling edge, then step the model at
  // the rising edge. Returns 1 time unit after the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_state();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_total = 0;
    m_ovf = 1'b0;
    m_prev = 1'b0;
    m_armed = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_total", total, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic rand_data(input logic [31:0] tag);
    cx = $urandom; cy = $urandom; cz = $urandom;
    nx = $urandom; ny = $urandom; nz = $urandom;
    dp = $urandom; g2 = $urandom; g1 = tag;
  endtask

  // One done pulse: a high cycle followed by a low cycle.
  task automatic pulse(input logic r, input logic [31:0] tag);
    rand_data(tag);
    done = 1'b1; ret = r;
    cycle();
    done = 1'b0;
    cycle();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    do_reset();
    cycle();

    // Scenario 1: a single contact with known field values.
    cx = 32'h0; cy = 32'h0; cz = 32'h3FC00000;
    nx = 32'hBF800000; ny = 32'h0; nz = 32'h0;
    dp = 32'h3C6F0000; g1 = 32'h3F7AE148; g2 = 32'h1;
    done = 1'b1; ret = 1'b1;
    cycle();
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_cx", out_cx, 32'h0);
    chk("s1_cz", out_cz, 32'h3FC00000);
    chk("s1_nx", out_nx, 32'hBF800000);
    chk("s1_depth", out_depth, 32'h3C6F0000);
    chk("s1_g1", out_g1, 32'h3F7AE148);
    chk("s1_g2", out_g2, 32'h1);
    chk("s1_count", count, 1);
    chk("s1_total", total, 1);
    done = 1'b0;
    cycle();

    // Scenario 2: a ret=0 edge, then done held high for 10 cycles.
    do_flush();
    pulse(1'b0, 32'd7);
    chk("s2_count", count, 0);
    chk("s2_total", total, 0);
    rand_data(32'd8);
    done = 1'b1; ret = 1'b1;
    repeat (10) cycle();
    done = 1'b0;
    cycle();
    chk("s2_held", count, 1);

    // Scenario 3: fill past capacity, then drain in order.
    do_flush();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) pulse(1'b1, i);
    chk("s3_full", full, 1'b1);
    chk("s3_count", count, 8);
    chk("s3_ovf", overflow, 1'b1);
    chk("s3_total", total, 8);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("s3_order", out_g1, i);
      cycle();
    end
    chk("s3_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // Scenario 4: push and pop together at count=3 across pointer wrap.
    do_flush();
    for (int i = 0; i < 3; i++) pulse(1'b1, 100 + i);
    for (int k = 0; k < 20; k++) begin
      rand_data(103 + k);
      done = 1'b1; ret = 1'b1; out_ready = 1'b1;
      chk("s4_head", out_g1, 100 + k);
      cycle();
      chk("s4_count", count, 3);
      done = 1'b0; out_ready = 1'b0;
      cycle();
    end

    // Scenario 5a: flush with a push pending, while count=5 and overflow=1.
    do_flush();
    for (int i = 0; i < 9; i++) pulse(1'b1, 200 + i);
    out_ready = 1'b1;
    repeat (3) cycle();
    out_ready = 1'b0;
    chk("s5_count5", count, 5);
    chk("s5_ovf1", overflow, 1'b1);
    rand_data(32'd300);
    flush = 1'b1; done = 1'b1; ret = 1'b1;
    cycle();
    flush = 1'b0; done = 1'b0;
    chk("s5_fl_count", count, 0);
    chk("s5_fl_total", total, 0);
    chk("s5_fl_ovf", overflow, 1'b0);
    cycle();

    // Scenario 5b: async reset mid-drain, then release with done already high.
    for (int i = 0; i < 4; i++) pulse(1'b1, 400 + i);
    out_ready = 1'b1;
    cycle();
    #2 rst = 1'b0;
    #1;
    chk("s5_async_valid", out_valid, 1'b0);
    chk("s5_async_count", count, 0);
    model_reset();
    out_ready = 1'b0;
    rand_data(32'd500);
    done = 1'b1; ret = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) cycle();
    chk("s5_rel_held", count, 0);
    done = 1'b0;
    cycle();
    pulse(1'b1, 32'd501);
    chk("s5_rearm", count, 1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rand_data($urandom);
      done = $urandom_range(0, 1);
      ret = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 60) == 0);
      cycle();
    end
    flush = 1'b0; done = 1'b0; out_ready = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
